// File: rtl/execute_mem_store_queue.sv
// In-order store queue: holds speculative stores until retire commits them, then
// drains committed entries to data memory. Define EXECUTE_MEM_SQ_FORWARD_EN for load forwarding.
module execute_mem_store_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_enq_valid,
    output logic                       o_enq_ready,
    input  logic [31:0]                i_enq_addr,
    input  logic [3:0]                 i_enq_strb,
    input  logic [31:0]                i_enq_data,
    input  logic                       i_commit,
    input  logic                       i_flush,
    output logic                       o_mem_valid,
    input  logic                       i_mem_ready,
    output logic [31:0]                o_mem_addr,
    output logic [3:0]                 o_mem_strb,
    output logic [31:0]                o_mem_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
`ifdef EXECUTE_MEM_SQ_FORWARD_EN
    ,
    input  logic [31:0]                i_fwd_addr,
    output logic                       o_fwd_hit,
    output logic [3:0]                 o_fwd_strb,
    output logic [31:0]                o_fwd_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [29:0]   addr_q [DEPTH];
    logic [3:0]    strb_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head, cptr, tail;
    logic [CW-1:0] count, ccount;

    logic          enq_fire, commit_fire, drain_fire;
    logic [PW-1:0] head_n, cptr_n, tail_n;
    logic [CW-1:0] count_n, ccount_n;

    // Entries store only the word address; the byte offset never reaches memory.
    logic unused_enq_lsb;
    assign unused_enq_lsb = ^i_enq_addr[1:0];

    assign o_enq_ready = (count < CW'(DEPTH));
    assign o_mem_valid = (ccount != '0);
    assign o_mem_addr  = {addr_q[head], 2'b00};
    assign o_mem_strb  = strb_q[head];
    assign o_mem_data  = data_q[head];
    assign o_count     = count;
    assign o_empty     = (count == '0);

    assign enq_fire    = i_enq_valid && o_enq_ready && !i_flush;
    assign commit_fire = i_commit && (count != ccount);
    assign drain_fire  = o_mem_valid && i_mem_ready;

    // A flush rewinds tail to the commit boundary after this cycle's commit.
    always_comb begin
        head_n   = head + PW'(drain_fire);
        cptr_n   = cptr + PW'(commit_fire);
        ccount_n = ccount + CW'(commit_fire) - CW'(drain_fire);
        tail_n   = i_flush ? cptr_n : tail + PW'(enq_fire);
        count_n  = i_flush ? ccount_n : count + CW'(enq_fire) - CW'(drain_fire);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head   <= '0;
            cptr   <= '0;
            tail   <= '0;
            count  <= '0;
            ccount <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                strb_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head   <= head_n;
            cptr   <= cptr_n;
            tail   <= tail_n;
            count  <= count_n;
            ccount <= ccount_n;
            if (enq_fire) begin
                addr_q[tail] <= i_enq_addr[31:2];
                strb_q[tail] <= i_enq_strb;
                data_q[tail] <= i_enq_data;
            end
        end
    end

`ifdef EXECUTE_MEM_SQ_FORWARD_EN
    logic          unused_fwd_lsb;
    logic [PW-1:0] fwd_idx;
    assign unused_fwd_lsb = ^i_fwd_addr[1:0];

    // Walk oldest to youngest so younger matching stores overwrite each lane.
    always_comb begin
        o_fwd_strb = '0;
        o_fwd_data = '0;
        fwd_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (i < int'(count) && addr_q[fwd_idx] == i_fwd_addr[31:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb_q[fwd_idx][b]) begin
                        o_fwd_strb[b]         = 1'b1;
                        o_fwd_data[8*b +: 8]  = data_q[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign o_fwd_hit = |o_fwd_strb;
`endif

endmodule
